alu_arith_sequencer: RTL and testbench

ALU_ARITH_SEQUENCER -- requirements
Module: alu_arith_sequencer

---
 rtl/alu_arith_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_alu_arith_sequencer.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arith_sequencer.sv
// alu_arith_sequencer: accepts one arithmetic command at a time, issues it to an
// external registered arithmetic unit, waits for its completion flag (bounded by
// TIMEOUT cycles) and holds the result as a response until it is consumed.
// Optional build macro: ALU_SEQ_DIVZERO_CHK_EN -- when defined, a divide command
// with a zero divisor is answered immediately with an error response and is
// never sent to the arithmetic unit.
module alu_arith_sequencer #(
  parameter int WIDTH       = 16,
  parameter int ARITH_WIDTH = 2 * WIDTH,
  parameter int TIMEOUT     = 4
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [1:0]             cmd_op,
  input  logic [WIDTH-1:0]       cmd_a,
  input  logic [WIDTH-1:0]       cmd_b,
  output logic [WIDTH-1:0]       A,
  output logic [WIDTH-1:0]       B,
  output logic [1:0]             ALU_FUN,
  output logic                   Arith_Enable,
  input  logic [ARITH_WIDTH-1:0] Arith_OUT,
  input  logic                   Carry_OUT,
  input  logic                   Arith_Flag,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [ARITH_WIDTH-1:0] rsp_data,
  output logic                   rsp_carry,
  output logic                   rsp_err,
  output logic                   busy,
  output logic [7:0]             rsp_count
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    WAIT  = 2'b10,
    RESP  = 2'b11
  } state_t;

  localparam logic [1:0] OP_DIV = 2'b11;

  state_t state_q;
  state_t state_nxt;

  logic signed [WIDTH-1:0]       op_a_p0;
  logic signed [WIDTH-1:0]       op_b_p0;
  logic [1:0]                    op_fun_p0;
  logic [CNT_W-1:0]              wait_cnt_q;
  logic [CNT_W-1:0]              wait_cnt_inc;
  logic                          timeout_hit;
  logic signed [ARITH_WIDTH-1:0] rsp_data_p1;
  logic                          rsp_carry_p1;
  logic                          rsp_err_p1;
  logic [7:0]                    rsp_count_q;
  logic                          div_zero;

  function automatic logic is_div_zero(input logic [1:0] op,
                                       input logic [WIDTH-1:0] divisor);
    is_div_zero = (op == OP_DIV) && (divisor == '0);
  endfunction

  assign wait_cnt_inc = wait_cnt_q + 1'b1;
  assign timeout_hit  = !Arith_Flag && (wait_cnt_inc == CNT_W'(TIMEOUT));
  assign div_zero     = is_div_zero(cmd_op, cmd_b);

  // State register; reset aborts any command in flight.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
`ifdef ALU_SEQ_DIVZERO_CHK_EN
          state_nxt = div_zero ? RESP : ISSUE;
`else
          state_nxt = ISSUE;
`endif
        end
      end
      ISSUE: state_nxt = WAIT;
      WAIT: begin
        if (Arith_Flag || timeout_hit) begin
          state_nxt = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---- command latch / issue stage (p0) ----
  // Operands and opcode are captured on accept and held until the next accept.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      op_a_p0   <= '0;
      op_b_p0   <= '0;
      op_fun_p0 <= '0;
    end else if (state_q == IDLE && cmd_valid) begin
      op_a_p0   <= signed'(cmd_a);
      op_b_p0   <= signed'(cmd_b);
      op_fun_p0 <= cmd_op;
    end
  end

  // Wait-cycle counter, cleared while issuing and advanced on each idle flag.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wait_cnt_q <= '0;
    end else if (state_q == ISSUE) begin
      wait_cnt_q <= '0;
    end else if (state_q == WAIT && !Arith_Flag) begin
      wait_cnt_q <= wait_cnt_inc;
    end
  end

  // ---- response stage (p1) ----
  // Response payload: unit result on completion, zeroed error on timeout or
  // (optionally) on a rejected divide-by-zero; frozen while RESP waits.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rsp_data_p1  <= '0;
      rsp_carry_p1 <= 1'b0;
      rsp_err_p1   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
`ifdef ALU_SEQ_DIVZERO_CHK_EN
          if (cmd_valid && div_zero) begin
            rsp_data_p1  <= '0;
            rsp_carry_p1 <= 1'b0;
            rsp_err_p1   <= 1'b1;
          end
`endif
        end
        WAIT: begin
          if (Arith_Flag) begin
            rsp_data_p1  <= signed'(Arith_OUT);
            rsp_carry_p1 <= Carry_OUT;
            rsp_err_p1   <= 1'b0;
          end else if (timeout_hit) begin
            rsp_data_p1  <= '0;
            rsp_carry_p1 <= 1'b0;
            rsp_err_p1   <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Completed-response counter, wraps naturally at 8 bits.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rsp_count_q <= '0;
    end else if (state_q == RESP && rsp_ready) begin
      rsp_count_q <= rsp_count_q + 8'd1;
    end
  end

`ifndef ALU_SEQ_DIVZERO_CHK_EN
  logic unused_div_zero;
  assign unused_div_zero = div_zero;
`endif

  assign cmd_ready    = (state_q == IDLE);
  assign Arith_Enable = (state_q == ISSUE);
  assign rsp_valid    = (state_q == RESP);
  assign busy         = (state_q != IDLE);
  assign A            = op_a_p0;
  assign B            = op_b_p0;
  assign ALU_FUN      = op_fun_p0;
  assign rsp_data     = rsp_data_p1;
  assign rsp_carry    = rsp_carry_p1;
  assign rsp_err      = rsp_err_p1;
  assign rsp_count    = rsp_count_q;

endmodule

// File: tb/tb_alu_arith_sequencer.sv
// Directed bench for alu_arith_sequencer with a 1-cycle registered arithmetic
// unit model. Inputs are driven and outputs sampled on the falling clock edge.
module tb_alu_arith_sequencer;

  localparam int WIDTH = 16;
  localparam int AW    = 32;

  logic          CLK;
  logic          RST;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic [15:0]   cmd_a;
  logic [15:0]   cmd_b;
  logic [15:0]   A;
  logic [15:0]   B;
  logic [1:0]    ALU_FUN;
  logic          Arith_Enable;
  logic [31:0]   Arith_OUT;
  logic          Carry_OUT;
  logic          Arith_Flag;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [31:0]   rsp_data;
  logic          rsp_carry;
  logic          rsp_err;
  logic          busy;
  logic [7:0]    rsp_count;

  logic          model_en;
  int            checks;
  int            errors;

  alu_arith_sequencer #(.WIDTH(WIDTH), .ARITH_WIDTH(AW), .TIMEOUT(4)) dut (
    .CLK(CLK), .RST(RST),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b),
    .A(A), .B(B), .ALU_FUN(ALU_FUN), .Arith_Enable(Arith_Enable),
    .Arith_OUT(Arith_OUT), .Carry_OUT(Carry_OUT), .Arith_Flag(Arith_Flag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_carry(rsp_carry), .rsp_err(rsp_err),
    .busy(busy), .rsp_count(rsp_count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [31:0] model_res(input logic [1:0] op,
                                            input logic [15:0] a,
                                            input logic [15:0] b);
    logic signed [31:0] ea;
    logic signed [31:0] eb;
    ea = {{16{a[15]}}, a};
    eb = {{16{b[15]}}, b};
    case (op)
      2'b00:   model_res = ea + eb;
      2'b01:   model_res = ea - eb;
      2'b10:   model_res = ea * eb;
      default: model_res = (eb == 0) ? 32'd0 : ea / eb;
    endcase
  endfunction

  function automatic logic model_carry(input logic [1:0] op,
                                       input logic [15:0] a,
                                       input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    model_carry = (op == 2'b00) ? s[16] : 1'b0;
  endfunction

  // Registered arithmetic unit: result and flag one cycle after enable.
  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      Arith_OUT  <= '0;
      Carry_OUT  <= 1'b0;
      Arith_Flag <= 1'b0;
    end else begin
      Arith_Flag <= Arith_Enable && model_en;
      if (Arith_Enable) begin
        Arith_OUT <= model_res(ALU_FUN, A, B);
        Carry_OUT <= model_carry(ALU_FUN, A, B);
      end
    end
  end

  task automatic check_val(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  // Offer a command in IDLE; returns just after the accept edge.
  task automatic send_cmd(input logic [1:0] op, input logic [15:0] a,
                          input logic [15:0] b);
    cmd_op    = op;
    cmd_a     = a;
    cmd_b     = b;
    cmd_valid = 1'b1;
    check_val("cmd_ready_before_accept", {31'd0, cmd_ready}, 32'd1);
    cycle();
    cmd_valid = 1'b0;
  endtask

  task automatic do_reset();
    RST = 1'b0;
    cycle();
    RST = 1'b1;
    cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int accepts;
    int last_acc;
    int gap_err;
    int cyc;
    checks    = 0;
    errors    = 0;
    RST       = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_a     = '0;
    cmd_b     = '0;
    rsp_ready = 1'b1;
    model_en  = 1'b1;
    @(negedge CLK);
    cycle();

    // Reset values while RST is held low
    check_val("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check_val("rst_arith_en", {31'd0, Arith_Enable}, 32'd0);
    check_val("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check_val("rst_busy", {31'd0, busy}, 32'd0);
    check_val("rst_rsp_count", {24'd0, rsp_count}, 32'd0);
    check_val("rst_rsp_data", rsp_data, 32'd0);
    check_val("rst_a", {16'd0, A}, 32'd0);
    RST = 1'b1;
    cycle();

    // Add 5 + 7, consumer ready
    send_cmd(2'b00, 16'd5, 16'd7);
    check_val("add_issue_en", {31'd0, Arith_Enable}, 32'd1);
    check_val("add_issue_a", {16'd0, A}, 32'd5);
    check_val("add_issue_b", {16'd0, B}, 32'd7);
    check_val("add_issue_fun", {30'd0, ALU_FUN}, 32'd0);
    check_val("add_issue_busy", {31'd0, busy}, 32'd1);
    cycle();
    check_val("add_wait_en", {31'd0, Arith_Enable}, 32'd0);
    check_val("add_wait_valid", {31'd0, rsp_valid}, 32'd0);
    cycle();
    check_val("add_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    check_val("add_rsp_data", rsp_data, 32'd12);
    check_val("add_rsp_err", {31'd0, rsp_err}, 32'd0);
    check_val("add_rsp_carry", {31'd0, rsp_carry}, 32'd0);
    cycle();
    check_val("add_count", {24'd0, rsp_count}, 32'd1);
    check_val("add_idle_valid", {31'd0, rsp_valid}, 32'd0);

    // Mul -3 * 100 with consumer stalled 5 cycles; a competing command is offered
    rsp_ready = 1'b0;
    send_cmd(2'b10, 16'hFFFD, 16'd100);
    check_val("mul_issue_fun", {30'd0, ALU_FUN}, 32'd2);
    cycle();
    cycle();
    check_val("mul_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    check_val("mul_rsp_data", rsp_data, 32'hFFFF_FED4);
    cmd_valid = 1'b1;
    cmd_op    = 2'b00;
    cmd_a     = 16'd1;
    cmd_b     = 16'd1;
    for (int i = 0; i < 5; i++) begin
      cycle();
      check_val("mul_stall_valid", {31'd0, rsp_valid}, 32'd1);
      check_val("mul_stall_data", rsp_data, 32'hFFFF_FED4);
      check_val("mul_stall_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    end
    check_val("mul_stall_a_hold", {16'd0, A}, 32'h0000_FFFD);
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    cycle();
    check_val("mul_done_valid", {31'd0, rsp_valid}, 32'd0);
    check_val("mul_count", {24'd0, rsp_count}, 32'd2);

    // Arithmetic unit never flags completion -> timeout error
    model_en = 1'b0;
    send_cmd(2'b00, 16'd1, 16'd2);
    for (int i = 0; i < 4; i++) begin
      cycle();
      check_val("to_wait_valid", {31'd0, rsp_valid}, 32'd0);
    end
    cycle();
    check_val("to_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    check_val("to_rsp_err", {31'd0, rsp_err}, 32'd1);
    check_val("to_rsp_data", rsp_data, 32'd0);
    cycle();
    check_val("to_count", {24'd0, rsp_count}, 32'd3);
    model_en = 1'b1;

    // Divide 9 / 0
    send_cmd(2'b11, 16'd9, 16'd0);
`ifdef ALU_SEQ_DIVZERO_CHK_EN
    check_val("dz_no_enable", {31'd0, Arith_Enable}, 32'd0);
    check_val("dz_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    check_val("dz_rsp_err", {31'd0, rsp_err}, 32'd1);
    check_val("dz_rsp_data", rsp_data, 32'd0);
    cycle();
`else
    check_val("dz_enable", {31'd0, Arith_Enable}, 32'd1);
    cycle();
    cycle();
    check_val("dz_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    check_val("dz_rsp_err", {31'd0, rsp_err}, 32'd0);
    cycle();
`endif
    check_val("dz_count", {24'd0, rsp_count}, 32'd4);

    // Reset asserted mid-WAIT discards the command
    send_cmd(2'b01, 16'd10, 16'd3);
    cycle();
    check_val("rw_in_wait_busy", {31'd0, busy}, 32'd1);
    RST = 1'b0;
    #1;
    check_val("rw_busy", {31'd0, busy}, 32'd0);
    check_val("rw_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check_val("rw_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check_val("rw_a", {16'd0, A}, 32'd0);
    check_val("rw_b", {16'd0, B}, 32'd0);
    check_val("rw_fun", {30'd0, ALU_FUN}, 32'd0);
    check_val("rw_count", {24'd0, rsp_count}, 32'd0);
    check_val("rw_data", rsp_data, 32'd0);
    cycle();
    RST = 1'b1;
    cycle();
    check_val("rw_no_response", {31'd0, rsp_valid}, 32'd0);
    send_cmd(2'b01, 16'd10, 16'd3);
    cycle();
    cycle();
    check_val("sub_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    check_val("sub_rsp_data", rsp_data, 32'd7);
    cycle();
    check_val("sub_count", {24'd0, rsp_count}, 32'd1);

    // 256 back-to-back adds, consumer always ready
    do_reset();
    accepts   = 0;
    last_acc  = 0;
    gap_err   = 0;
    cyc       = 0;
    cmd_valid = 1'b1;
    cmd_op    = 2'b00;
    cmd_a     = 16'd1;
    cmd_b     = 16'd1;
    while (accepts < 256 && cyc < 3000) begin
      if (cmd_ready) begin
        if (accepts > 0 && (cyc - last_acc) != 4) gap_err++;
        last_acc = cyc;
        accepts++;
      end
      cycle();
      cyc++;
    end
    cmd_valid = 1'b0;
    check_val("b2b_accepts", accepts, 32'd256);
    check_val("b2b_gap_errors", gap_err, 32'd0);
    check_val("b2b_last_accept_cycle", last_acc, 32'd1020);
    check_val("b2b_count_255", {24'd0, rsp_count}, 32'd255);
    cycle();
    cycle();
    cycle();
    check_val("b2b_count_wrap", {24'd0, rsp_count}, 32'd0);
    check_val("b2b_idle", {31'd0, busy}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
